// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the imem address and registers one IF/ID entry with a valid/ready handshake.
// Optional macro IFETCH_PERF_EN adds the fetch and stall performance counters.
module ifetch_ctrl #(
  parameter int unsigned      XLEN      = 64,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter int unsigned      MEM_WORDS = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  output logic            if_exc_en_o,
  output logic [3:0]      if_exc_code_o,
  output logic [XLEN-1:0] if_exc_val_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [63:0]     perf_fetch_cnt_o,
  output logic [63:0]     perf_stall_cnt_o
`endif
);

  localparam logic [31:0]     NOP        = 32'h0000_0013;
  localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(MEM_WORDS);
  localparam logic [3:0]      EXC_MISALIGN = 4'd0;
  localparam logic [3:0]      EXC_ACCESS   = 4'd1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    FAULT_HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [31:0]     instr_q, instr_d;
  logic            exc_en_q, exc_en_d;
  logic [3:0]      exc_code_q, exc_code_d;
  logic [XLEN-1:0] exc_val_q, exc_val_d;

  logic load;
  logic accept;
  logic misaligned;
  logic out_of_range;

  assign load         = (state_q == FETCH) && (!valid_q || if_ready_i);
  assign accept       = valid_q && if_ready_i;
  assign misaligned   = (pc_q[1:0] != 2'b00);
  // Full-width word index compare so high PCs can never alias into the array.
  assign out_of_range = (pc_q[XLEN-1:2] >= WORD_LIMIT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    ifpc_d     = ifpc_q;
    instr_d    = instr_q;
    exc_en_d   = exc_en_q;
    exc_code_d = exc_code_q;
    exc_val_d  = exc_val_q;

    if (accept) begin
      valid_d = 1'b0;
    end

    if (redirect_en_i) begin
      state_d    = FETCH;
      pc_d       = redirect_pc_i;
      valid_d    = 1'b0;
      exc_en_d   = 1'b0;
      exc_code_d = 4'd0;
      exc_val_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (load) begin
            valid_d = 1'b1;
            ifpc_d  = pc_q;
            if (misaligned || out_of_range) begin
              instr_d    = NOP;
              exc_en_d   = 1'b1;
              exc_code_d = misaligned ? EXC_MISALIGN : EXC_ACCESS;
              exc_val_d  = pc_q;
              state_d    = FAULT_HOLD;
            end else begin
              instr_d    = imem_rdata_i;
              exc_en_d   = 1'b0;
              exc_code_d = 4'd0;
              exc_val_d  = '0;
              pc_d       = pc_q + XLEN'(4);
            end
          end
        end
        FAULT_HOLD: begin
          state_d = FAULT_HOLD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      ifpc_q     <= '0;
      instr_q    <= NOP;
      exc_en_q   <= 1'b0;
      exc_code_q <= 4'd0;
      exc_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      ifpc_q     <= ifpc_d;
      instr_q    <= instr_d;
      exc_en_q   <= exc_en_d;
      exc_code_q <= exc_code_d;
      exc_val_q  <= exc_val_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_valid_o    = valid_q;
  assign if_pc_o       = ifpc_q;
  assign if_instr_o    = instr_q;
  assign if_exc_en_o   = exc_en_q;
  assign if_exc_code_o = exc_code_q;
  assign if_exc_val_o  = exc_val_q;

`ifdef IFETCH_PERF_EN
  logic [63:0] fetch_cnt_q;
  logic [63:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && !exc_en_q) begin
        fetch_cnt_q <= fetch_cnt_q + 64'd1;
      end
      if (valid_q && !if_ready_i) begin
        stall_cnt_q <= stall_cnt_q + 64'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
